gb_pulse_channel_gen: RTL and testbench

Parametrised next-generation pulse channel for the APU, used for Channels 1 and 2. It generalises period, length and volume widths and the period prescale. It adds DAC gating, a trigger-time sweep overflow check, length-enable gating and latched channel disable. It sits between the register file / frame sequencer and the mixer, producing one VOL_W-bit level per channel.

---
 rtl/gb_apu_pkg.sv | 30 +++
 rtl/gb_pulse_channel_gen_if.sv | 45 ++++
 rtl/gb_sweep_unit.sv | 83 ++++++++
 rtl/gb_pulse_channel_gen.sv | 145 ++++++++++++++
 tb/tb_gb_pulse_channel_gen.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gb_apu_pkg.sv
// Shared APU definitions: duty selection, the duty waveform lookup and the
// default channel widths.
package gb_apu_pkg;

    localparam int DEFAULT_PERIOD_W = 11;
    localparam int DEFAULT_LENGTH_W = 6;
    localparam int DEFAULT_VOL_W    = 4;
    localparam int DEFAULT_PRESCALE = 4;

    typedef enum logic [1:0] {
        DUTY_12 = 2'd0,
        DUTY_25 = 2'd1,
        DUTY_50 = 2'd2,
        DUTY_75 = 2'd3
    } duty_e;

    // High when the 8-step waveform selected by duty is high at this phase.
    function automatic logic duty_bit(input duty_e duty, input logic [2:0] phase);
        logic bit_v;
        case (duty)
            DUTY_12: bit_v = (phase == 3'd7);
            DUTY_25: bit_v = (phase[2:1] == 2'b11);
            DUTY_50: bit_v = phase[2];
            DUTY_75: bit_v = (phase <= 3'd5);
            default: bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

endpackage

// File: rtl/gb_pulse_channel_gen_if.sv
// Control/data bundle between register file + frame sequencer (master) and
// one pulse channel (slave).
interface gb_pulse_channel_gen_if
    import gb_apu_pkg::*;
#(
    parameter int PERIOD_W = DEFAULT_PERIOD_W,
    parameter int LENGTH_W = DEFAULT_LENGTH_W,
    parameter int VOL_W    = DEFAULT_VOL_W
) ();

    logic                tick_length;
    logic                tick_envelope;
    logic                tick_sweep;
    logic                trigger;
    logic                dac_enable;
    logic                length_enable;
    logic [LENGTH_W-1:0] length_load;
    logic [1:0]          duty;
    logic [VOL_W-1:0]    initial_volume;
    logic                envelope_increasing;
    logic [2:0]          envelope_pace;
    logic [2:0]          sweep_pace;
    logic                sweep_decreasing;
    logic [2:0]          sweep_shift;
    logic [PERIOD_W-1:0] period;
    logic [VOL_W-1:0]    level;
    logic                enable;

    modport master (
        output tick_length, tick_envelope, tick_sweep, trigger, dac_enable,
               length_enable, length_load, duty, initial_volume,
               envelope_increasing, envelope_pace, sweep_pace,
               sweep_decreasing, sweep_shift, period,
        input  level, enable
    );

    modport slave (
        input  tick_length, tick_envelope, tick_sweep, trigger, dac_enable,
               length_enable, length_load, duty, initial_volume,
               envelope_increasing, envelope_pace, sweep_pace,
               sweep_decreasing, sweep_shift, period,
        output level, enable
    );

endinterface

// File: rtl/gb_sweep_unit.sv
// Frequency sweep: shadow period, sweep timer and overflow detection. The kill
// output is combinational so the channel drops enable on the same edge.
module gb_sweep_unit
    import gb_apu_pkg::*;
#(
    parameter bit SWEEP_EN = 1'b1,
    parameter int PERIOD_W = DEFAULT_PERIOD_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic                tick_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [2:0]          pace_i,
    input  logic                decreasing_i,
    input  logic [2:0]          shift_i,
    output logic [PERIOD_W-1:0] shadow_o,
    output logic                overflow_kill_o
);

    localparam logic [PERIOD_W:0] PERIOD_MAX = {1'b0, {PERIOD_W{1'b1}}};

    logic [PERIOD_W-1:0] shadow_q, shadow_d;
    logic [3:0]          timer_q, timer_d;
    logic [3:0]          timer_reload;
    logic [PERIOD_W:0]   calc_new;
    logic                new_ovf, chk_ovf, trig_ovf;
    logic                kill;

    function automatic logic [PERIOD_W:0] sweep_calc(input logic [PERIOD_W-1:0] base,
                                                     input logic dec,
                                                     input logic [2:0] sh);
        logic [PERIOD_W:0] b;
        b = {1'b0, base};
        return dec ? (b - (b >> sh)) : (b + (b >> sh));
    endfunction

    assign timer_reload = (pace_i == 3'd0) ? 4'd8 : {1'b0, pace_i};
    assign calc_new     = sweep_calc(shadow_q, decreasing_i, shift_i);
    assign new_ovf      = calc_new > PERIOD_MAX;
    assign chk_ovf      = sweep_calc(calc_new[PERIOD_W-1:0], decreasing_i, shift_i) > PERIOD_MAX;
    assign trig_ovf     = sweep_calc(period_i, 1'b0, shift_i) > PERIOD_MAX;

    always_comb begin
        shadow_d = shadow_q;
        timer_d  = timer_q;
        kill     = 1'b0;
        if (start_i) begin
            shadow_d = period_i;
            timer_d  = timer_reload;
            if ((shift_i != 3'd0) && !decreasing_i && trig_ovf) kill = 1'b1;
        end else if (tick_i) begin
            if (timer_q <= 4'd1) begin
                timer_d = timer_reload;
                if (pace_i != 3'd0) begin
                    if (new_ovf) begin
                        kill = 1'b1;
                    end else if (shift_i != 3'd0) begin
                        // The look-ahead check only kills; shadow keeps the first result.
                        shadow_d = calc_new[PERIOD_W-1:0];
                        if (chk_ovf) kill = 1'b1;
                    end
                end
            end else begin
                timer_d = timer_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            timer_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            timer_q  <= timer_d;
        end
    end

    assign shadow_o        = SWEEP_EN ? shadow_q : period_i;
    assign overflow_kill_o = SWEEP_EN & kill;

endmodule

// File: rtl/gb_pulse_channel_gen.sv
// APU pulse channel (CH1/CH2): trigger, length, envelope, period divider and
// duty generator producing one registered level for the mixer.
module gb_pulse_channel_gen
    import gb_apu_pkg::*;
#(
    parameter int PERIOD_W = DEFAULT_PERIOD_W,
    parameter int LENGTH_W = DEFAULT_LENGTH_W,
    parameter int VOL_W    = DEFAULT_VOL_W,
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter bit SWEEP_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    gb_pulse_channel_gen_if.slave bus
);

    localparam int                 PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]    PS_RELOAD = PS_W'(PRESCALE - 1);
    localparam logic [LENGTH_W:0]  LEN_FULL  = {1'b1, {LENGTH_W{1'b0}}};
    localparam logic [LENGTH_W:0]  LEN_ONE   = (LENGTH_W + 1)'(1);
    localparam logic [VOL_W-1:0]   VOL_MAX   = '1;
    localparam logic [VOL_W-1:0]   VOL_ONE   = VOL_W'(1);

    logic                trig_q, first_q;
    logic                enable_q, enable_d;
    logic [VOL_W-1:0]    level_q, level_d;
    logic [LENGTH_W:0]   len_ctr_q, len_ctr_d;
    logic [VOL_W-1:0]    vol_q, vol_d;
    logic [2:0]          env_timer_q, env_timer_d;
    logic [PERIOD_W-1:0] divider_q, divider_d;
    logic [PS_W-1:0]     prescaler_q, prescaler_d;
    logic [2:0]          phase_q, phase_d;
    logic                start;
    logic                tick_ok;
    logic [PERIOD_W-1:0] shadow;
    logic                overflow_kill;

    // first_q blanks the first cycle after reset so a trigger held through reset
    // is taken as the previous level rather than a fresh rising edge.
    assign start   = bus.trigger & ~trig_q & ~first_q;
    assign tick_ok = ~start & bus.dac_enable;

    gb_sweep_unit #(
        .SWEEP_EN (SWEEP_EN),
        .PERIOD_W (PERIOD_W)
    ) u_sweep (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start),
        .tick_i          (bus.tick_sweep & tick_ok),
        .period_i        (bus.period),
        .pace_i          (bus.sweep_pace),
        .decreasing_i    (bus.sweep_decreasing),
        .shift_i         (bus.sweep_shift),
        .shadow_o        (shadow),
        .overflow_kill_o (overflow_kill)
    );

    always_comb begin
        enable_d    = enable_q;
        len_ctr_d   = len_ctr_q;
        vol_d       = vol_q;
        env_timer_d = env_timer_q;
        if (start) begin
            enable_d    = bus.dac_enable & ~overflow_kill;
            len_ctr_d   = LEN_FULL - {1'b0, bus.length_load};
            vol_d       = bus.initial_volume;
            env_timer_d = bus.envelope_pace;
        end else if (!bus.dac_enable) begin
            enable_d = 1'b0;
        end else begin
            if (bus.tick_length && bus.length_enable && (len_ctr_q != '0)) begin
                len_ctr_d = len_ctr_q - LEN_ONE;
                if (len_ctr_q == LEN_ONE) enable_d = 1'b0;
            end
            if (overflow_kill) enable_d = 1'b0;
            if (bus.tick_envelope && (bus.envelope_pace != 3'd0)) begin
                if (env_timer_q <= 3'd1) begin
                    env_timer_d = bus.envelope_pace;
                    if (bus.envelope_increasing) begin
                        if (vol_q != VOL_MAX) vol_d = vol_q + VOL_ONE;
                    end else if (vol_q != '0) begin
                        vol_d = vol_q - VOL_ONE;
                    end
                end else begin
                    env_timer_d = env_timer_q - 3'd1;
                end
            end
        end
    end

    // Divider counts up to all-ones, then reloads from the sweep shadow and steps the phase.
    always_comb begin
        divider_d   = divider_q;
        prescaler_d = prescaler_q;
        phase_d     = phase_q;
        if (start) begin
            divider_d   = bus.period;
            prescaler_d = PS_RELOAD;
            phase_d     = 3'd0;
        end else if (prescaler_q == '0) begin
            prescaler_d = PS_RELOAD;
            if (&divider_q) begin
                divider_d = shadow;
                phase_d   = phase_q + 3'd1;
            end else begin
                divider_d = divider_q + 1'b1;
            end
        end else begin
            prescaler_d = prescaler_q - 1'b1;
        end
    end

    assign level_d = (enable_q && duty_bit(duty_e'(bus.duty), phase_q)) ? vol_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            trig_q      <= 1'b0;
            first_q     <= 1'b1;
            enable_q    <= 1'b0;
            level_q     <= '0;
            len_ctr_q   <= '0;
            vol_q       <= '0;
            env_timer_q <= '0;
            divider_q   <= '0;
            prescaler_q <= '0;
            phase_q     <= '0;
        end else begin
            trig_q      <= bus.trigger;
            first_q     <= 1'b0;
            enable_q    <= enable_d;
            level_q     <= level_d;
            len_ctr_q   <= len_ctr_d;
            vol_q       <= vol_d;
            env_timer_q <= env_timer_d;
            divider_q   <= divider_d;
            prescaler_q <= prescaler_d;
            phase_q     <= phase_d;
        end
    end

    assign bus.level  = level_q;
    assign bus.enable = enable_q;

endmodule

// File: tb/tb_gb_pulse_channel_gen.sv
// Scoreboard bench for gb_pulse_channel_gen: a behavioural channel model pushes
// the expected enable/level per edge; a monitor pops and compares.
module tb_gb_pulse_channel_gen;

    localparam int PW   = 11;
    localparam int LW   = 6;
    localparam int VW   = 4;
    localparam int PS   = 4;
    localparam int PMAX = (1 << PW) - 1;
    localparam int VMAX = (1 << VW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gb_pulse_channel_gen_if #(.PERIOD_W(PW), .LENGTH_W(LW), .VOL_W(VW)) bus ();

    gb_pulse_channel_gen #(
        .PERIOD_W (PW),
        .LENGTH_W (LW),
        .VOL_W    (VW),
        .PRESCALE (PS),
        .SWEEP_EN (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic          en;
        logic [VW-1:0] lvl;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference state: what the channel is doing, in plain integers.
    int     m_en, m_vol, m_len, m_env, m_shadow, m_swt, m_phase, m_lvl, m_trig, m_first;
    longint m_next;

    function automatic int sweep_calc(input int s, input int dec, input int sh);
        return (dec != 0) ? (s - (s >> sh)) : (s + (s >> sh));
    endfunction

    function automatic int duty_high(input int d, input int p);
        int r;
        case (d)
            0:       r = (p == 7) ? 1 : 0;
            1:       r = (p >= 6) ? 1 : 0;
            2:       r = (p >= 4) ? 1 : 0;
            default: r = (p <= 5) ? 1 : 0;
        endcase
        return r;
    endfunction

    task automatic model_step();
        int trig, dac, tl, te, ts, len_en, lload, duty, ivol, einc, epace;
        int space, sdec, sshift, per, lvl_nx, start, n;
        trig = int'(bus.trigger);          dac    = int'(bus.dac_enable);
        tl = int'(bus.tick_length);        te     = int'(bus.tick_envelope);
        ts = int'(bus.tick_sweep);         len_en = int'(bus.length_enable);
        lload = int'(bus.length_load);     duty   = int'(bus.duty);
        ivol = int'(bus.initial_volume);   einc   = int'(bus.envelope_increasing);
        epace = int'(bus.envelope_pace);   space  = int'(bus.sweep_pace);
        sdec = int'(bus.sweep_decreasing); sshift = int'(bus.sweep_shift);
        per = int'(bus.period);
        if (reset) begin
            m_en = 0; m_vol = 0; m_len = 0; m_env = 0; m_shadow = 0; m_swt = 0;
            m_phase = 0; m_lvl = 0; m_trig = 0; m_first = 1; m_next = -1;
            return;
        end
        lvl_nx  = (m_en != 0 && duty_high(duty, m_phase) != 0) ? m_vol : 0;
        start   = (trig != 0 && m_trig == 0 && m_first == 0) ? 1 : 0;
        m_trig  = trig;
        m_first = 0;
        if (start == 0 && longint'(cyc) == m_next) begin
            m_phase = (m_phase + 1) % 8;
            m_next  = cyc + PS * (PMAX + 1 - m_shadow);
        end
        if (start != 0) begin
            m_len    = (1 << LW) - lload;
            m_vol    = ivol;
            m_env    = epace;
            m_shadow = per;
            m_swt    = (space == 0) ? 8 : space;
            m_phase  = 0;
            m_next   = cyc + PS * (PMAX + 1 - per);
            m_en     = dac;
            if (sshift != 0 && sdec == 0 && sweep_calc(per, 0, sshift) > PMAX) m_en = 0;
        end else if (dac == 0) begin
            m_en = 0;
        end else begin
            if (tl != 0 && len_en != 0 && m_len > 0) begin
                m_len--;
                if (m_len == 0) m_en = 0;
            end
            if (te != 0 && epace != 0) begin
                if (m_env <= 1) begin
                    m_env = epace;
                    if (einc != 0) m_vol = (m_vol < VMAX) ? m_vol + 1 : VMAX;
                    else           m_vol = (m_vol > 0) ? m_vol - 1 : 0;
                end else begin
                    m_env--;
                end
            end
            if (ts != 0) begin
                if (m_swt <= 1) begin
                    m_swt = (space == 0) ? 8 : space;
                    if (space != 0) begin
                        n = sweep_calc(m_shadow, sdec, sshift);
                        if (n > PMAX) begin
                            m_en = 0;
                        end else if (sshift != 0) begin
                            m_shadow = n;
                            if (sweep_calc(n, sdec, sshift) > PMAX) m_en = 0;
                        end
                    end
                end else begin
                    m_swt--;
                end
            end
        end
        m_lvl = lvl_nx;
    endtask

    // Inputs are already set; predict the coming edge and advance to the next negedge.
    task automatic cycle_drive();
        model_step();
        exp_q.push_back('{en: (m_en != 0), lvl: VW'(m_lvl), cyc: cyc});
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n, input int pl = 0, input int pe = 0, input int ps = 0);
        for (int i = 0; i < n; i++) begin
            bus.tick_length   = ($urandom_range(0, 99) < pl);
            bus.tick_envelope = ($urandom_range(0, 99) < pe);
            bus.tick_sweep    = ($urandom_range(0, 99) < ps);
            cycle_drive();
        end
        bus.tick_length   = 1'b0;
        bus.tick_envelope = 1'b0;
        bus.tick_sweep    = 1'b0;
    endtask

    task automatic trig_pulse(input int pl = 0, input int pe = 0, input int ps = 0);
        bus.trigger = 1'b1;
        run(1, pl, pe, ps);
        bus.trigger = 1'b0;
    endtask

    task automatic set_cfg(input int duty, input int per, input int vol, input int einc,
                           input int epace, input int space, input int sdec,
                           input int sshift, input int lload, input int len_en);
        bus.duty                = 2'(duty);
        bus.period              = PW'(per);
        bus.initial_volume      = VW'(vol);
        bus.envelope_increasing = 1'(einc);
        bus.envelope_pace       = 3'(epace);
        bus.sweep_pace          = 3'(space);
        bus.sweep_decreasing    = 1'(sdec);
        bus.sweep_shift         = 3'(sshift);
        bus.length_load         = LW'(lload);
        bus.length_enable       = 1'(len_en);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                checks++;
                if (bus.enable !== mon_e.en) begin
                    failures++;
                    $display("FAIL enable cyc=%0d got=%0b expected=%0b", mon_e.cyc, bus.enable, mon_e.en);
                end
                checks++;
                if (bus.level !== mon_e.lvl) begin
                    failures++;
                    $display("FAIL level cyc=%0d got=%0d expected=%0d", mon_e.cyc, bus.level, mon_e.lvl);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.trigger = 1'b0;
        bus.dac_enable = 1'b1;
        bus.tick_length = 1'b0;
        bus.tick_envelope = 1'b0;
        bus.tick_sweep = 1'b0;
        set_cfg(3, PMAX, 15, 0, 0, 0, 0, 0, 0, 0);
        run(3);
        reset = 1'b0;
        run(3);

        // 75% duty at the fastest period: 24 clks high, 8 low.
        trig_pulse();
        run(80);

        // Length 62 -> two ticks disable; extra ticks keep it off; retrigger restores.
        set_cfg(3, PMAX, 9, 0, 0, 0, 0, 0, 62, 1);
        trig_pulse();
        run(3); run(1, 100); run(3); run(1, 100); run(3);
        run(2, 100); run(3);
        trig_pulse();
        run(6);

        // Length tick coincident with trigger is ignored.
        trig_pulse(100);
        run(2); run(1, 100); run(2); run(1, 100); run(3);

        // Envelope down from 2 saturating at 0, then up from 15 saturating at 15.
        set_cfg(3, PMAX, 2, 0, 1, 0, 0, 0, 0, 0);
        trig_pulse();
        for (int i = 0; i < 4; i++) begin run(1, 0, 100); run(4); end
        set_cfg(3, PMAX, 15, 1, 1, 0, 0, 0, 0, 0);
        trig_pulse();
        for (int i = 0; i < 3; i++) begin run(1, 0, 100); run(4); end

        // Trigger-time overflow, then decreasing sweep 0x700 -> 0x380.
        set_cfg(3, 'h700, 12, 0, 0, 1, 0, 1, 0, 0);
        trig_pulse();
        run(5);
        set_cfg(3, 'h700, 12, 0, 0, 1, 1, 1, 0, 0);
        trig_pulse();
        run(1, 0, 0, 100);
        run(1100);

        // Decreasing shift 3 from 2047 -> shadow 1792, phase steps every 1024 clks.
        set_cfg(2, PMAX, 7, 0, 0, 1, 1, 3, 0, 0);
        trig_pulse();
        run(1, 0, 0, 100);
        run(3200);

        // DAC off disables; raising it does not re-enable; trigger with DAC off stays off.
        set_cfg(3, PMAX, 15, 0, 0, 0, 0, 0, 0, 0);
        trig_pulse();
        run(10);
        bus.dac_enable = 1'b0; run(5);
        bus.dac_enable = 1'b1; run(5);
        bus.dac_enable = 1'b0; trig_pulse(); run(4);
        bus.dac_enable = 1'b1; run(4);
        trig_pulse(); run(10);

        // Reset mid-tone, and a trigger held high across reset release.
        reset = 1'b1; run(1); reset = 1'b0; run(3);
        bus.trigger = 1'b1; reset = 1'b1; run(2); reset = 1'b0; run(6);
        bus.trigger = 1'b0; run(2);
        trig_pulse(); run(10);

        for (int ep = 0; ep < 30; ep++) begin
            set_cfg(int'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) != 0) ? int'($urandom_range(2016, 2047))
                                                : int'($urandom_range(0, 2047)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 63)), int'($urandom_range(0, 1)));
            bus.dac_enable = ($urandom_range(0, 9) != 0);
            trig_pulse(int'($urandom_range(0, 1)) * 100, 0, int'($urandom_range(0, 1)) * 100);
            run(int'($urandom_range(50, 250)), int'($urandom_range(0, 20)),
                int'($urandom_range(0, 20)), int'($urandom_range(0, 20)));
            case ($urandom_range(0, 3))
                0: begin
                    bus.dac_enable = 1'b0; run(5, 10, 10, 10);
                    bus.dac_enable = 1'b1; run(5, 10, 10, 10);
                end
                1: begin
                    reset = 1'b1; run(1); reset = 1'b0; run(2);
                end
                default: run(5);
            endcase
        end

        run(3);
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
